comp_seq_wide: RTL and testbench

Sequential unsigned magnitude comparator for operands wider than one 32-bit word. It accepts two WORDS×32-bit operands as a stream of 32-bit word pairs, most-significant word first, over a valid/ready handshake. It produces the bigger/equal/smaller flags that the 32-bit comparator produces for a single word. The block sits where wide (e.g. 128-bit) keys or counters must be compared without instantiating a wide combinational comparator.

---
 rtl/comp_seq_wide_if.sv | 25 ++
 rtl/comp_seq_wide.sv | 109 ++++++++++
 tb/tb_comp_seq_wide.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/comp_seq_wide_if.sv
// rtl/comp_seq_wide_if.sv - word-pair stream and result flags for comp_seq_wide
interface comp_seq_wide_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             valid_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             ready_o;
  logic             busy_o;
  logic             done_o;
  logic             bg_o;
  logic             eq_o;
  logic             sl_o;

  modport slave (
    input  start_i, valid_i, a_i, b_i,
    output ready_o, busy_o, done_o, bg_o, eq_o, sl_o
  );

  modport master (
    output start_i, valid_i, a_i, b_i,
    input  ready_o, busy_o, done_o, bg_o, eq_o, sl_o
  );
endinterface

// File: rtl/comp_seq_wide.sv
// rtl/comp_seq_wide.sv - sequential unsigned comparator over WORDS x WIDTH operands, MSW first
module comp_seq_wide #(
  parameter int WORDS = 4,
  parameter int WIDTH = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  comp_seq_wide_if.slave bus
);
  localparam int               CNT_W = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run_bg, r_run_eq, r_run_sl;
  logic             r_ready, r_busy, r_done;
  logic             r_bg, r_eq, r_sl;

  logic [WIDTH-1:0] w_a, w_b;
  logic             w_hs;
  logic             w_bg, w_eq, w_sl;

  assign w_a  = bus.a_i;
  assign w_b  = bus.b_i;
  assign w_hs = bus.valid_i && r_ready;

  // Decision freezes once a word differs; the more significant word dominates.
  always_comb begin
    w_bg = r_run_bg;
    w_eq = r_run_eq;
    w_sl = r_run_sl;
    if (r_run_eq) begin
      if (w_a > w_b) begin
        w_bg = 1'b1;
        w_eq = 1'b0;
      end else if (w_a < w_b) begin
        w_sl = 1'b1;
        w_eq = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_run_bg <= 1'b0;
      r_run_eq <= 1'b1;
      r_run_sl <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bg     <= 1'b0;
      r_eq     <= 1'b1;
      r_sl     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start_i) begin
            r_state  <= S_RUN;
            r_cnt    <= '0;
            r_run_bg <= 1'b0;
            r_run_eq <= 1'b1;
            r_run_sl <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_hs) begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_run_bg <= w_bg;
            r_run_eq <= w_eq;
            r_run_sl <= w_sl;
            if (r_cnt == LAST) begin
              r_state <= S_DONE;
              r_ready <= 1'b0;
              r_done  <= 1'b1;
              r_bg    <= w_bg;
              r_eq    <= w_eq;
              r_sl    <= w_sl;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o = r_ready;
  assign bus.busy_o  = r_busy;
  assign bus.done_o  = r_done;
  assign bus.bg_o    = r_bg;
  assign bus.eq_o    = r_eq;
  assign bus.sl_o    = r_sl;
endmodule

// File: tb/tb_comp_seq_wide.sv
// tb/tb_comp_seq_wide.sv - directed and reference-model bench for comp_seq_wide
module tb_comp_seq_wide;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  comp_seq_wide_if #(.WIDTH(32)) bus ();

  comp_seq_wide #(.WORDS(4), .WIDTH(32)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full comparison from start to the first IDLE cycle; inputs change 1 time unit after each edge.
  task automatic do_compare(input logic [127:0] a, input logic [127:0] b,
                            input int gap_after, input int gap_len,
                            output int lat, output logic dn, output logic dn_next,
                            output logic busy_next, output logic early,
                            output logic gap_ready, output logic [2:0] flags);
    lat       = 0;
    early     = 1'b0;
    gap_ready = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    lat = 1;
    for (int w = 0; w < 4; w++) begin
      bus.valid_i = 1'b1;
      bus.a_i     = a[127-32*w -: 32];
      bus.b_i     = b[127-32*w -: 32];
      if (bus.done_o !== 1'b0) early = 1'b1;
      @(posedge clk); #1;
      lat++;
      if (w == gap_after) begin
        bus.valid_i = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          if (bus.ready_o !== 1'b1) gap_ready = 1'b0;
          if (bus.done_o !== 1'b0) early = 1'b1;
          @(posedge clk); #1;
          lat++;
        end
      end
    end
    bus.valid_i = 1'b0;
    dn    = bus.done_o;
    flags = {bus.bg_o, bus.eq_o, bus.sl_o};
    @(posedge clk); #1;
    dn_next   = bus.done_o;
    busy_next = bus.busy_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.a_i = '0;
    bus.b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({bus.ready_o, bus.busy_o, bus.done_o} !== 3'b000)
      $display("FAIL reset_ctrl: got ready/busy/done=%b want 000", {bus.ready_o, bus.busy_o, bus.done_o});
    else n_pass++;
    n_total++;
    if ({bus.bg_o, bus.eq_o, bus.sl_o} !== 3'b010)
      $display("FAIL reset_flags: got %b want 010", {bus.bg_o, bus.eq_o, bus.sl_o});
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic dn, dnn, bn, early, gr; logic [2:0] fl;
    do_compare(128'h0000_0000_0000_0000_0000_0000_0000_0005,
               128'h0000_0000_0000_0000_0000_0000_0000_0003,
               -1, 0, lat, dn, dnn, bn, early, gr, fl);
    n_total++;
    if (dn !== 1'b1 || lat != 5 || early !== 1'b0)
      $display("FAIL basic_done: got done=%b at %0d early=%b want done=1 at 5 early=0", dn, lat, early);
    else n_pass++;
    n_total++;
    if (fl !== 3'b100) $display("FAIL basic_flags: got %b want 100", fl);
    else n_pass++;
    n_total++;
    if (dnn !== 1'b0 || bn !== 1'b0)
      $display("FAIL basic_after: got done=%b busy=%b want 0 0", dnn, bn);
    else n_pass++;
  endtask

  task automatic test_msw_dominance();
    int lat; logic dn, dnn, bn, early, gr; logic [2:0] fl;
    do_compare(128'h8000_0000_0000_0000_0000_0000_0000_0000,
               128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
               -1, 0, lat, dn, dnn, bn, early, gr, fl);
    n_total++;
    if (dn !== 1'b1 || fl !== 3'b100)
      $display("FAIL msw_dominance: got done=%b flags=%b want 1 100", dn, fl);
    else n_pass++;
    do_compare(128'h0000_0001_0000_0000_0000_0000_0000_0000,
               128'h0000_0001_0000_0000_FFFF_FFFF_0000_0000,
               -1, 0, lat, dn, dnn, bn, early, gr, fl);
    n_total++;
    if (dn !== 1'b1 || fl !== 3'b001)
      $display("FAIL third_word_less: got done=%b flags=%b want 1 001", dn, fl);
    else n_pass++;
  endtask

  task automatic test_gap();
    int lat; logic dn, dnn, bn, early, gr; logic [2:0] fl;
    do_compare({4{32'hDEADBEEF}}, {4{32'hDEADBEEF}}, 1, 3,
               lat, dn, dnn, bn, early, gr, fl);
    n_total++;
    if (dn !== 1'b1 || lat != 8 || early !== 1'b0)
      $display("FAIL gap_done: got done=%b at %0d early=%b want done=1 at 8 early=0", dn, lat, early);
    else n_pass++;
    n_total++;
    if (gr !== 1'b1) $display("FAIL gap_ready: got ready_during_gap=%b want 1", gr);
    else n_pass++;
    n_total++;
    if (fl !== 3'b010) $display("FAIL gap_flags: got %b want 010", fl);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat; logic dn, dnn, bn, early, gr; logic [2:0] fl, exp_fl;
    logic [127:0] a, b;
    logic [31:0] wa;
    for (int i = 0; i < 700; i++) begin
      for (int w = 0; w < 4; w++) begin
        wa = $urandom;
        a[32*w +: 32] = wa;
        b[32*w +: 32] = (i >= 500 || $urandom_range(0, 1) == 1) ? wa : 32'($urandom);
      end
      exp_fl = (a > b) ? 3'b100 : (a < b) ? 3'b001 : 3'b010;
      do_compare(a, b, -1, 0, lat, dn, dnn, bn, early, gr, fl);
      n_total++;
      if (dn !== 1'b1 || dnn !== 1'b0 || fl !== exp_fl ||
          {bus.bg_o, bus.eq_o, bus.sl_o} !== exp_fl)
        $display("FAIL random_%0d: a=%h b=%h got done=%b%b flags=%b held=%b want 10 %b",
                 i, a, b, dn, dnn, fl, {bus.bg_o, bus.eq_o, bus.sl_o}, exp_fl);
      else n_pass++;
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic dn, dnn, bn, early, gr; logic [2:0] fl;
    do_compare(128'h1, 128'h2, -1, 0, lat, dn, dnn, bn, early, gr, fl);
    n_total++;
    if (fl !== 3'b001) $display("FAIL abort_pre: got %b want 001", fl);
    else n_pass++;
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    for (int w = 0; w < 2; w++) begin
      bus.valid_i = 1'b1;
      bus.a_i = 32'h9;
      bus.b_i = 32'h1;
      @(posedge clk); #1;
    end
    bus.valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({bus.ready_o, bus.busy_o, bus.done_o, bus.bg_o, bus.eq_o, bus.sl_o} !== 6'b000_010)
      $display("FAIL abort_now: got rdy/busy/done/bg/eq/sl=%b want 000010",
               {bus.ready_o, bus.busy_o, bus.done_o, bus.bg_o, bus.eq_o, bus.sl_o});
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.done_o !== 1'b0) $display("FAIL abort_nodone: got done=%b want 0", bus.done_o);
    else n_pass++;
    rst = 1'b0;
    do_compare(128'hFFFF_0000_0000_0000_0000_0000_0000_0001,
               128'hFFFF_0000_0000_0000_0000_0000_0000_0000,
               -1, 0, lat, dn, dnn, bn, early, gr, fl);
    n_total++;
    if (dn !== 1'b1 || lat != 5 || fl !== 3'b100)
      $display("FAIL abort_next: got done=%b at %0d flags=%b want 1 at 5 100", dn, lat, fl);
    else n_pass++;
  endtask

  task automatic test_start_and_valid_ignored();
    logic [2:0] prev;
    prev = {bus.bg_o, bus.eq_o, bus.sl_o};
    for (int c = 0; c < 3; c++) begin
      bus.valid_i = 1'b1;
      bus.a_i = 32'h1;
      bus.b_i = 32'h7;
      @(posedge clk); #1;
      n_total++;
      if ({bus.ready_o, bus.busy_o, bus.done_o} !== 3'b000 ||
          {bus.bg_o, bus.eq_o, bus.sl_o} !== prev)
        $display("FAIL idle_valid_%0d: got rdy/busy/done=%b flags=%b want 000 %b",
                 c, {bus.ready_o, bus.busy_o, bus.done_o}, {bus.bg_o, bus.eq_o, bus.sl_o}, prev);
      else n_pass++;
    end
    bus.valid_i = 1'b0;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (bus.ready_o !== 1'b1) $display("FAIL held_start_run: got ready=%b want 1", bus.ready_o);
    else n_pass++;
    for (int w = 0; w < 4; w++) begin
      bus.valid_i = 1'b1;
      bus.a_i = 32'h5;
      bus.b_i = 32'h5;
      @(posedge clk); #1;
    end
    bus.valid_i = 1'b0;
    n_total++;
    if ({bus.done_o, bus.busy_o, bus.ready_o, bus.bg_o, bus.eq_o, bus.sl_o} !== 6'b110_010)
      $display("FAIL held_start_done: got done/busy/rdy/bg/eq/sl=%b want 110010",
               {bus.done_o, bus.busy_o, bus.ready_o, bus.bg_o, bus.eq_o, bus.sl_o});
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({bus.busy_o, bus.ready_o, bus.done_o} !== 3'b000)
      $display("FAIL held_start_idle: got busy/rdy/done=%b want 000", {bus.busy_o, bus.ready_o, bus.done_o});
    else n_pass++;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    n_total++;
    if (bus.ready_o !== 1'b1) $display("FAIL held_start_restart: got ready=%b want 1", bus.ready_o);
    else n_pass++;
    for (int w = 0; w < 4; w++) begin
      bus.valid_i = 1'b1;
      bus.a_i = (w == 3) ? 32'h2 : 32'h0;
      bus.b_i = (w == 3) ? 32'h3 : 32'h0;
      @(posedge clk); #1;
    end
    bus.valid_i = 1'b0;
    n_total++;
    if (bus.done_o !== 1'b1 || {bus.bg_o, bus.eq_o, bus.sl_o} !== 3'b001)
      $display("FAIL held_start_result: got done=%b flags=%b want 1 001",
               bus.done_o, {bus.bg_o, bus.eq_o, bus.sl_o});
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_basic();
    test_msw_dominance();
    test_gap();
    test_reset_abort();
    test_start_and_valid_ignored();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
